// File: rtl/majority_vote_sequencer.sv
// Round-robin vote collector feeding a five-input majority decision.
// Define MAJ_RELATIVE_EN for relative majority over cast votes and the extra tie output.
module majority_vote_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TW      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] req,
    input  logic [4:0] vote,
    output logic [4:0] grant,
    output logic       busy,
    output logic       done,
    output logic       z,
    output logic [2:0] yes_cnt,
    output logic [4:0] abstain_mask
`ifdef MAJ_RELATIVE_EN
    ,
    output logic       tie
`endif
);

    typedef enum logic [1:0] {StIdle, StCollect, StDecide} state_e;

    state_e          state_q, state_d;
    logic [4:0]      voted_q, voted_d;
    logic [2:0]      tally_q, tally_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic            z_q, z_d;
    logic [2:0]      yes_cnt_q, yes_cnt_d;
    logic [4:0]      abstain_q, abstain_d;
    logic [4:0]      elig;
`ifdef MAJ_RELATIVE_EN
    logic            tie_q, tie_d;
    logic [2:0]      cast;
    logic [3:0]      yes_x2;
`endif

    // First eligible voter strictly after ptr, wrapping modulo 5.
    function automatic logic [4:0] rr_pick(input logic [4:0] e, input logic [2:0] ptr);
        logic [4:0] g;
        logic       found;
        logic [2:0] idx;
        g     = '0;
        found = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            idx = 3'((int'(ptr) + k) % 5);
            if (!found && e[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

`ifdef MAJ_RELATIVE_EN
    function automatic logic [2:0] popcount5(input logic [4:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 5; i++) begin
            c = c + 3'(v[i]);
        end
        return c;
    endfunction
`endif

    always_comb begin
        elig  = req & ~voted_q;
        grant = (state_q == StCollect) ? rr_pick(elig, rr_ptr_q) : 5'b00000;
        busy  = (state_q != StIdle);
        done  = (state_q == StDecide);
    end

    always_comb begin
        state_d   = state_q;
        voted_d   = voted_q;
        tally_d   = tally_q;
        timer_d   = timer_q;
        rr_ptr_d  = rr_ptr_q;
        z_d       = z_q;
        yes_cnt_d = yes_cnt_q;
        abstain_d = abstain_q;
`ifdef MAJ_RELATIVE_EN
        tie_d     = tie_q;
        cast      = '0;
        yes_x2    = '0;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCollect;
                    voted_d = '0;
                    tally_d = '0;
                    timer_d = '0;
                end
            end
            StCollect: begin
                voted_d = voted_q | grant;
                tally_d = tally_q + {2'b00, |(grant & vote)};
                timer_d = timer_q + TW'(1);
                for (int i = 0; i < 5; i++) begin
                    if (grant[i]) rr_ptr_d = 3'(i);
                end
                // Decision uses the tally including any vote taken on this edge.
                if (voted_d == 5'b11111 || timer_q == TW'(TIMEOUT - 1)) begin
                    state_d   = StDecide;
                    yes_cnt_d = tally_d;
                    abstain_d = ~voted_d;
`ifdef MAJ_RELATIVE_EN
                    cast      = popcount5(voted_d);
                    yes_x2    = {tally_d, 1'b0};
                    z_d       = (yes_x2 > {1'b0, cast});
                    tie_d     = (yes_x2 == {1'b0, cast});
`else
                    z_d       = (tally_d >= 3'd3);
`endif
                end
            end
            StDecide: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            voted_q   <= '0;
            tally_q   <= '0;
            timer_q   <= '0;
            rr_ptr_q  <= 3'd4;
            z_q       <= 1'b0;
            yes_cnt_q <= '0;
            abstain_q <= '0;
`ifdef MAJ_RELATIVE_EN
            tie_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            voted_q   <= voted_d;
            tally_q   <= tally_d;
            timer_q   <= timer_d;
            rr_ptr_q  <= rr_ptr_d;
            z_q       <= z_d;
            yes_cnt_q <= yes_cnt_d;
            abstain_q <= abstain_d;
`ifdef MAJ_RELATIVE_EN
            tie_q     <= tie_d;
`endif
        end
    end

    assign z            = z_q;
    assign yes_cnt      = yes_cnt_q;
    assign abstain_mask = abstain_q;
`ifdef MAJ_RELATIVE_EN
    assign tie          = tie_q;
`endif

endmodule

// File: tb/tb_majority_vote_sequencer.sv
// Bench for majority_vote_sequencer: directed scenarios plus random traffic against a ballot model.
module tb_majority_vote_sequencer;

    localparam int unsigned TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] req = '0;
    logic [4:0] vote = '0;
    logic [4:0] grant;
    logic       busy;
    logic       done;
    logic       z;
    logic [2:0] yes_cnt;
    logic [4:0] abstain_mask;
`ifdef MAJ_RELATIVE_EN
    logic       tie;
`endif

    always #5 clk = ~clk;

    majority_vote_sequencer #(
        .TIMEOUT (TIMEOUT),
        .TW      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .req          (req),
        .vote         (vote),
        .grant        (grant),
        .busy         (busy),
        .done         (done),
        .z            (z),
        .yes_cnt      (yes_cnt),
        .abstain_mask (abstain_mask)
`ifdef MAJ_RELATIVE_EN
        ,
        .tie          (tie)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Ballot model: phase 0 idle, 1 collecting, 2 deciding.
    bit m_valid = 0;
    int m_phase = 0;
    bit m_voted [5];
    bit m_abs   [5];
    int m_yes = 0, m_cycles = 0, m_ptr = 4;
    int m_z = 0, m_yes_out = 0, m_tie = 0;

    function automatic int model_grant();
        if (m_phase != 1) return -1;
        for (int k = 1; k <= 5; k++) begin
            int i;
            i = (m_ptr + k) % 5;
            if (req[i] && !m_voted[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        int cast;
        if (rst) begin
            m_valid = 1; m_phase = 0; m_yes = 0; m_cycles = 0; m_ptr = 4;
            m_z = 0; m_yes_out = 0; m_tie = 0;
            for (int i = 0; i < 5; i++) begin m_voted[i] = 0; m_abs[i] = 0; end
        end else if (m_valid) begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_yes = 0; m_cycles = 0;
                    for (int i = 0; i < 5; i++) m_voted[i] = 0;
                end
                1: begin
                    g = model_grant();
                    if (g >= 0) begin m_voted[g] = 1; m_yes += int'(vote[g]); m_ptr = g; end
                    m_cycles++;
                    cast = 0;
                    for (int i = 0; i < 5; i++) cast += int'(m_voted[i]);
                    if (cast == 5 || m_cycles == TIMEOUT) begin
                        m_phase = 2;
                        m_yes_out = m_yes;
                        for (int i = 0; i < 5; i++) m_abs[i] = !m_voted[i];
`ifdef MAJ_RELATIVE_EN
                        m_z   = (m_yes > cast - m_yes) ? 1 : 0;
                        m_tie = (m_yes == cast - m_yes) ? 1 : 0;
`else
                        m_z   = (m_yes >= 3) ? 1 : 0;
`endif
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        int g;
        logic [4:0] eg;
        logic [4:0] ea;
        if (m_valid) begin
            g  = model_grant();
            eg = '0;
            if (g >= 0) eg[g] = 1'b1;
            for (int i = 0; i < 5; i++) ea[i] = m_abs[i];
            check("grant", 32'(grant), 32'(eg));
            check("busy", 32'(busy), (m_phase != 0) ? 1 : 0);
            check("done", 32'(done), (m_phase == 2) ? 1 : 0);
            check("z", 32'(z), m_z);
            check("yes_cnt", 32'(yes_cnt), m_yes_out);
            check("abstain_mask", 32'(abstain_mask), 32'(ea));
`ifdef MAJ_RELATIVE_EN
            check("tie", 32'(tie), m_tie);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the cycle number (1 = first COLLECT cycle) in which done is seen.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin n = c; break; end
            tick();
        end
        if (n == 0) check({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic full_round(input string tag, input logic [4:0] v, input logic ez,
                              input logic [2:0] ey);
        logic [4:0] e;
        req = 5'b11111; vote = v; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            e = 5'b00001 << c;
            check({tag, "_grant"}, 32'(grant), 32'(e));
            tick();
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_yes"}, 32'(yes_cnt), 32'(ey));
        check({tag, "_abs"}, 32'(abstain_mask), 0);
`ifndef MAJ_RELATIVE_EN
        check({tag, "_z"}, 32'(z), 32'(ez));
`endif
        tick();
    endtask

    initial begin
        int n;
        int ndone;
        int order [5];
        logic [4:0] e;
        order = '{3, 4, 0, 1, 2};

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_z", 32'(z), 0);
        check("rst_yes", 32'(yes_cnt), 0);
        tick();

        full_round("t1", 5'b01011, 1'b1, 3'd3);
        full_round("t2", 5'b11000, 1'b0, 3'd2);

        // Partial turnout ends by timeout.
        req = 5'b01010; vote = 5'b01010; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t3", n);
        check("t3_cycle", n, TIMEOUT + 1);
        check("t3_yes", 32'(yes_cnt), 2);
        check("t3_abs", 32'(abstain_mask), 32'h15);
`ifdef MAJ_RELATIVE_EN
        check("t3_z", 32'(z), 1);
        check("t3_tie", 32'(tie), 0);
`else
        check("t3_z", 32'(z), 0);
`endif
        tick();

        // Fairness carries across rounds.
        req = 5'b00100; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t4a", n);
        tick();
        req = 5'b11111; vote = 5'b10101; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            e = '0;
            e[order[c]] = 1'b1;
            check("t4_grant", 32'(grant), 32'(e));
            tick();
        end
        @(negedge clk);
        check("t4_done", 32'(done), 1);
        tick();

        // Mid-ballot reset discards the round and restores voter 0 priority.
        req = 5'b11111; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy", 32'(busy), 0);
        check("t5_grant", 32'(grant), 0);
        check("t5_z", 32'(z), 0);
        check("t5_yes", 32'(yes_cnt), 0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("t5_first_grant", 32'(grant), 1);
        tick();
        wait_done("t5", n);
        tick();

        // Held start runs one round, then restarts only once back in idle.
        req = 5'b11111; start = 1'b1;
        tick();
        ndone = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (done) ndone++;
            if (c == 7) check("t6_idle_busy", 32'(busy), 0);
            tick();
        end
        check("t6_done_pulses", ndone, 1);
        start = 1'b0;
        @(negedge clk);
        check("t6_restart_busy", 32'(busy), 1);
        tick();
        wait_done("t6", n);
        tick();

        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 79) == 0);
            start = ($urandom_range(0, 3) == 0);
            req   = ($urandom_range(0, 1) == 0) ? 5'b11111 : 5'($urandom);
            vote  = 5'($urandom);
            tick();
        end
        rst = 1'b0; start = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
